// File: rtl/router_out_arbiter.sv
// router_out_arbiter: per-output round-robin arbiter holding each grant until the owner's done pulse.
module router_out_arbiter #(
  parameter int NUM_PORTS = 16,
  parameter int ADDR_W    = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_da,
  input  logic [NUM_PORTS-1:0]        done,
  output logic [NUM_PORTS-1:0]        in_gnt,
  output logic [NUM_PORTS-1:0]        in_busy,
  output logic [NUM_PORTS-1:0]        out_own,
  output logic [NUM_PORTS*ADDR_W-1:0] out_sel,
  output logic                        proto_err
);
  typedef enum logic {IDLE, OWNED} state_t;
  state_t              state_q [NUM_PORTS];
  state_t              state_d [NUM_PORTS];
  logic [ADDR_W-1:0]   sel_q [NUM_PORTS];
  logic [ADDR_W-1:0]   sel_d [NUM_PORTS];
  logic [ADDR_W-1:0]   rr_q [NUM_PORTS];
  logic [ADDR_W-1:0]   rr_d [NUM_PORTS];
  logic [ADDR_W-1:0]   da [NUM_PORTS];
  logic [NUM_PORTS-1:0] gnt_q, gnt_d, req_q;
  logic                proto_err_q, proto_err_d, found;
  logic [ADDR_W-1:0]   idx;
  // Grants and releases touch disjoint inputs: a grant needs gnt_q low, a release needs it high.
  always_comb begin
    gnt_d = gnt_q;
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) da[i] = req_da[i*ADDR_W +: ADDR_W];
    for (int o = 0; o < NUM_PORTS; o++) begin
      state_d[o] = state_q[o];
      sel_d[o] = sel_q[o];
      rr_d[o] = rr_q[o];
      found = 1'b0;
      if (state_q[o] == OWNED) begin
        if (done[sel_q[o]]) begin
          state_d[o] = IDLE;
          gnt_d[sel_q[o]] = 1'b0;
          rr_d[o] = sel_q[o] + ADDR_W'(1);
        end
      end else begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          idx = rr_q[o] + ADDR_W'(k);
          if (!found && req[idx] && !gnt_q[idx] && da[idx] == ADDR_W'(o)) begin
            found = 1'b1;
            state_d[o] = OWNED;
            sel_d[o] = idx;
            gnt_d[idx] = 1'b1;
          end
        end
      end
    end
    proto_err_d = |((gnt_q & req_q & ~req & ~done) | (done & req & ~req_q & ~gnt_q));
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= '{default: IDLE};
      sel_q <= '{default: '0};
      rr_q <= '{default: '0};
      gnt_q <= '0;
      req_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      rr_q <= rr_d;
      gnt_q <= gnt_d;
      req_q <= req;
      proto_err_q <= proto_err_d;
    end
  end
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_out
    assign out_own[g] = state_q[g] == OWNED;
    assign out_sel[g*ADDR_W +: ADDR_W] = sel_q[g];
  end
  assign in_gnt = gnt_q;
  assign in_busy = req & ~gnt_q;
  assign proto_err = proto_err_q;
endmodule
